// File: rtl/iir_sample_feeder.sv
// iir_sample_feeder: FIFO-buffered pacer emitting single-cycle sample strobes to the IIR filter.
// Define FEEDER_GAIN_EN to shift each popped sample left by SHIFT with 16-bit saturation.
module iir_sample_feeder #(
   parameter int DEPTH = 8,
   parameter int GAP   = 0,
   parameter int SHIFT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic signed [15:0]       in_data_i,
   output logic                     data_en_o,
   output logic signed [15:0]       data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     busy_o
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;
   state_t state_q, state_d;
   logic signed [15:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0] level_q, level_d;
   logic [7:0] cnt_q, cnt_d;
   logic signed [15:0] data_q, data_d, sample;
   logic push, pop;
   assign in_ready_o = level_q != (AW+1)'(DEPTH) && !flush_i;
   assign push       = in_valid_i && in_ready_o;
`ifdef FEEDER_GAIN_EN
   logic signed [31:0] wide;
   assign wide   = 32'(mem_q[rd_q]) <<< SHIFT;
   assign sample = wide > 32'sd32767 ? 16'sh7fff : wide < -32'sd32768 ? 16'sh8000 : wide[15:0];
`else
   assign sample = mem_q[rd_q];
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      data_d  = '0;
      case (state_q)
         IDLE: pop = level_q != '0;
         EMIT: begin
            pop     = GAP == 0 && level_q != '0;
            cnt_d   = 8'(GAP - 1);
            state_d = GAP == 0 ? IDLE : WAIT;
         end
         WAIT: begin
            pop     = cnt_q == '0 && level_q != '0;
            cnt_d   = cnt_q - 8'd1;
            state_d = cnt_q == '0 ? IDLE : WAIT;
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         state_d = EMIT;
         data_d  = sample;
      end
      // flush outranks any pop decided above
      if (flush_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         pop     = 1'b0;
         data_d  = '0;
      end
      level_d = flush_i ? '0 : level_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         data_q  <= data_d;
         wr_q    <= flush_i ? '0 : wr_q + AW'(push);
         rd_q    <= flush_i ? '0 : rd_q + AW'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= in_data_i;
   assign data_en_o = state_q == EMIT;
   assign data_o    = data_q;
   assign level_o   = level_q;
   assign busy_o    = state_q != IDLE || level_q != '0;
endmodule
